arm_mc_controller: RTL and testbench
====================================

# arm_mc_controller

Multicycle control unit for the ARM subset core: ADD/SUB/AND/ORR, LDR/STR and B, all with condition codes. It replaces the single-cycle decoder/condlogic pair when the core moves to a shared instruction/data memory. It sequences fetch, decode, execute and writeback with a Moore FSM, owns the NZCV flag register, and stalls on a memory ready handshake. It drives the multicycle datapath's muxes and enables; the datapath holds the IR, Data, A, WriteData and ALUOut registers.

## Interface
- No parameters. All encodings come from `arm_mc_pkg`.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low. 0 forces the FSM to FETCH, clears Flags and deasserts every write enable.
- `Instr` in 20: IR bits [31:12], from the registered IR.
- `ALUFlags` in 4: {N,Z,C,V} from the ALU this cycle.
- `mem_ready` in 1: memory completed the access requested this cycle.
- `mem_req` out 1: memory access request.
- `PCWrite`, `RegWrite`, `MemWrite`, `IRWrite` out 1 each: register and memory write enables.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `ResultSrc` out 2: Result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 1: ALU A select. 0 = A register, 1 = PC.
- `ALUSrcB` out 2: ALU B select. 00 = WriteData, 01 = ExtImm, 10 = constant 4.
- `ImmSrc`, `RegSrc`, `ALUControl` out 2 each: same encodings as the single-cycle decoder. ALUControl: ADD 00, SUB 01, AND 10, ORR 11.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH:
  - Outputs: mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - IRWrite and PCWrite are asserted only while mem_ready=1.
  - Stay in FETCH while mem_ready=0. Go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. This makes R15 read as PC+8.
  - Compute CondEx from Cond (Instr[31:28]) and the Flags register.
  - If CondEx=0, or Op=11, or the DP funct is unimplemented: go to FETCH with no writes (NOP).
  - Otherwise branch on Op:
    - Op 01 (LDR/STR) -> MEMADR.
    - Op 00 with I=1 -> EXECI; Op 00 with I=0 -> EXECR.
    - Op 10 -> BRANCH.
- MEMADR:
  - Outputs: ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ALUControl=ADD.
  - Next state: MEMRD if L=1, MEMWR if L=0.
- MEMRD: mem_req=1, AdrSrc=1. Stay until mem_ready=1, then go to MEMWB.
- MEMWB:
  - Outputs: ResultSrc=01.
  - If Rd=15: PCWrite=1. Otherwise RegWrite=1.
  - Next state: FETCH.
- MEMWR:
  - Outputs: mem_req=1, MemWrite=1, AdrSrc=1, RegSrc[1]=1.
  - MemWrite stays asserted until mem_ready=1, then go to FETCH.
- EXECR / EXECI:
  - EXECR: ALUSrcA=0, ALUSrcB=00.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ImmSrc=00.
  - ALUControl comes from funct[4:1].
  - If S=1: N and Z are loaded from ALUFlags. C and V are loaded only for ADD/SUB.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: ResultSrc=00.
  - If Rd=15: PCWrite=1. Otherwise RegWrite=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: ALUSrcA=0, RegSrc[0]=1, ALUSrcB=01, ImmSrc=10, ALUControl=ADD, ResultSrc=10, PCWrite=1.
  - Next state: FETCH.
- Any output not listed for a state is 0. ImmSrc and RegSrc are driven from the decoded Op in every state.

## Timing
- Moore outputs, except that IRWrite/PCWrite in FETCH are qualified combinationally by mem_ready.
- Cycles per instruction with zero-wait memory:
  - DP: 4
  - LDR: 5
  - STR: 4
  - B: 3
  - Condition-failed instruction: 2
- Each cycle with mem_ready=0 adds one cycle in FETCH, MEMRD or MEMWR.
- Flags update on the clock edge that leaves EXECR/EXECI. A conditional instruction in the very next fetch sees the new flags.
- Reset value of every enable and mem_req is 0. FETCH outputs appear in the first cycle after reset deasserts.
- Reset asserted mid-instruction: within the same cycle, every write enable drops, the FSM returns to FETCH and Flags clear. No partial writeback may occur.
- mem_ready while mem_req=0 is ignored.

## Structure
- `arm_mc_pkg` holds:
  - the `state_t` enum;
  - ALUControl, ResultSrc, ALUSrcB and ImmSrc encoding constants;
  - Op field constants.
- Sub-module `condcheck` is reused unchanged for CondEx. It is instantiated once and fed from the Flags register.
- Flags are two enable-gated registers: {N,Z} and {C,V}.

## Test plan
- Reset low for 2 cycles, then high, mem_ready=1.
  - Expect mem_req=1 and IRWrite=1 in the first cycle.
  - All enables are 0 while reset is low.
- ADD R1,R0,#5 (E2801005), zero wait.
  - Expected state sequence: FETCH, DECODE, EXECI, ALUWB, FETCH.
  - RegWrite=1 in ALUWB only.
- SUBS R2,R1,R1 then ADDEQ R3,R0,#1, zero wait.
  - Z=1 is latched after EXECR.
  - ADDEQ executes and sets RegWrite=1.
- Repeat the previous case with ADDNE.
  - DECODE goes directly to FETCH.
  - No RegWrite in that instruction; CPI is 2.
- STR R2,[R0,#100] with mem_ready low for 3 cycles in MEMWR.
  - MemWrite stays high for 4 cycles.
  - The FSM returns to FETCH on the cycle after mem_ready=1.
- LDR R15,[R0,#0].
  - MEMWB asserts PCWrite=1 and RegWrite=0.
  - Reset pulsed during MEMRD gives FETCH and zero enables in the same cycle.

Source files
------------

// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states,
// datapath mux selects, ALU operations and instruction field constants.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  // ALUControl
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // ImmSrc
  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  // Op field
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  // Data-processing cmd field (funct[4:1])
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Map a DP cmd onto the ALU operation it needs
  function automatic logic [1:0] alu_op(input logic [3:0] cmd);
    case (cmd)
      CMD_SUB: return ALU_SUB;
      CMD_AND: return ALU_AND;
      CMD_ORR: return ALU_ORR;
      default: return ALU_ADD;
    endcase
  endfunction

  // True for the DP commands this core actually executes
  function automatic logic dp_supported(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
           (cmd == CMD_AND) || (cmd == CMD_ORR);
  endfunction

endpackage

// File: rtl/arm_mc_controller_condcheck.sv
// Condition-code evaluator: decides whether an instruction executes given
// its Cond field and the current {N,Z,C,V} flags.
module condcheck (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic neg, zero, carry, ovf, ge;

  assign {neg, zero, carry, ovf} = flags;
  assign ge = (neg == ovf);

  // Standard ARM condition table; 1111 is treated as always-execute
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = zero;
      4'b0001: cond_ex = ~zero;
      4'b0010: cond_ex = carry;
      4'b0011: cond_ex = ~carry;
      4'b0100: cond_ex = neg;
      4'b0101: cond_ex = ~neg;
      4'b0110: cond_ex = ovf;
      4'b0111: cond_ex = ~ovf;
      4'b1000: cond_ex = carry & ~zero;
      4'b1001: cond_ex = ~(carry & ~zero);
      4'b1010: cond_ex = ge;
      4'b1011: cond_ex = ~ge;
      4'b1100: cond_ex = ~zero & ge;
      4'b1101: cond_ex = ~(~zero & ge);
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle control unit: Moore FSM sequencing fetch/decode/execute/
// writeback over a shared memory with a ready handshake, plus the NZCV
// flag registers. Outputs drive the multicycle datapath muxes and enables.
module arm_mc_controller
  import arm_mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl
);

  // Instruction fields (Instr holds IR[31:12])
  logic [3:0] cond;
  logic [1:0] op;
  logic       imm_bit;
  logic [3:0] cmd;
  logic       s_bit;   // S for DP, L for memory ops
  logic [3:0] rd;
  logic       unused_instr;

  assign cond         = Instr[19:16];
  assign op           = Instr[15:14];
  assign imm_bit      = Instr[13];
  assign cmd          = Instr[12:9];
  assign s_bit        = Instr[8];
  assign rd           = Instr[3:0];
  assign unused_instr = ^Instr[7:4];

  state_t     state_reg, state_next;
  logic [1:0] nz_reg, cv_reg;
  logic       cond_ex;
  logic       in_exec;
  logic       nz_we, cv_we;
  logic       rd_is_pc;

  condcheck u_condcheck (
    .cond    (cond),
    .flags   ({nz_reg, cv_reg}),
    .cond_ex (cond_ex)
  );

  assign rd_is_pc = (rd == 4'd15);
  assign in_exec  = (state_reg == EXECR) || (state_reg == EXECI);
  // Logical ops only touch N/Z; C/V keep their previous values
  assign nz_we    = in_exec && s_bit;
  assign cv_we    = nz_we && ((cmd == CMD_ADD) || (cmd == CMD_SUB));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= FETCH;
    else        state_reg <= state_next;
  end

  // N/Z flag register, loaded as the FSM leaves EXECR/EXECI
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     nz_reg <= 2'b00;
    else if (nz_we) nz_reg <= ALUFlags[3:2];
  end

  // C/V flag register, loaded only by arithmetic ops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     cv_reg <= 2'b00;
    else if (cv_we) cv_reg <= ALUFlags[1:0];
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:  if (mem_ready) state_next = DECODE;
      DECODE: begin
        if (!cond_ex || op == OP_NOP ||
            (op == OP_DP && !dp_supported(cmd))) state_next = FETCH;
        else if (op == OP_MEM)                    state_next = MEMADR;
        else if (op == OP_BR)                     state_next = BRANCH;
        else if (imm_bit)                         state_next = EXECI;
        else                                      state_next = EXECR;
      end
      MEMADR: state_next = s_bit ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) state_next = MEMWB;
      MEMWR:  if (mem_ready) state_next = FETCH;
      EXECR:  state_next = ALUWB;
      EXECI:  state_next = ALUWB;
      default: state_next = FETCH;
    endcase
  end

  // Moore outputs; FETCH enables are qualified by mem_ready and
  // everything is forced low while reset is held
  always_comb begin
    mem_req    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_WDATA;
    ALUControl = ALU_ADD;
    // Immediate/register-source selects follow the decoded Op everywhere
    // so register reads in DECODE already see the right operands
    ImmSrc     = op;
    RegSrc     = {(op == OP_MEM) && !s_bit, op == OP_BR};
    case (state_reg)
      FETCH: begin
        mem_req   = 1'b1;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      MEMADR: ALUSrcB = SRCB_IMM;
      MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        PCWrite   = rd_is_pc;
        RegWrite  = !rd_is_pc;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      EXECR: ALUControl = alu_op(cmd);
      EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_op(cmd);
      end
      ALUWB: begin
        PCWrite  = rd_is_pc;
        RegWrite = !rd_is_pc;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        PCWrite   = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      mem_req    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = 2'b00;
      ImmSrc     = 2'b00;
      RegSrc     = 2'b00;
    end
  end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Bench for arm_mc_controller: a per-cycle stimulus table (inputs plus the
// state the controller should be in) drives the DUT; the expected output
// word is pushed to a scoreboard and compared on the falling edge.
module tb_arm_mc_controller;

  typedef enum int {
    B_RST, B_FETCH, B_DECODE, B_MEMADR, B_MEMRD, B_MEMWB,
    B_MEMWR, B_EXECR, B_EXECI, B_ALUWB, B_BRANCH
  } bst_t;

  typedef struct {
    logic        rst_n;
    logic [19:0] instr;
    logic [3:0]  aflags;
    logic        ready;
    bst_t        st;
  } vec_t;

  typedef struct {
    logic [16:0] outs;
    bst_t        st;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] Instr = '0;
  logic [3:0]  ALUFlags = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  vec_t vecs[$];

  arm_mc_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

  logic [16:0] act;
  assign act = {mem_req, PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};

  // Expected output word for a state, written from the controller's
  // output table
  function automatic logic [16:0] exp_outs(bst_t st, logic [19:0] ins, logic rdy);
    logic mreq, pcw, rw, mw, irw, adr, srca;
    logic [1:0] res, srcb, imm, rsrc, aluc, op;
    logic rdpc;
    op   = ins[15:14];
    rdpc = (ins[3:0] == 4'hF);
    {mreq, pcw, rw, mw, irw, adr, srca} = '0;
    res  = 2'b00; srcb = 2'b00; aluc = 2'b00;
    imm  = op;
    rsrc = {(op == 2'b01) && !ins[8], op == 2'b10};
    case (ins[12:9])
      4'b0010: aluc = 2'b01;
      4'b0000: aluc = 2'b10;
      4'b1100: aluc = 2'b11;
      default: aluc = 2'b00;
    endcase
    if (st != B_EXECR && st != B_EXECI) aluc = 2'b00;
    case (st)
      B_RST:    return '0;
      B_FETCH:  begin mreq = 1; irw = rdy; pcw = rdy; srca = 1; srcb = 2'b10; res = 2'b10; end
      B_DECODE: begin srca = 1; srcb = 2'b10; res = 2'b10; end
      B_MEMADR: srcb = 2'b01;
      B_MEMRD:  begin mreq = 1; adr = 1; end
      B_MEMWB:  begin res = 2'b01; pcw = rdpc; rw = !rdpc; end
      B_MEMWR:  begin mreq = 1; mw = 1; adr = 1; end
      B_EXECR:  ;
      B_EXECI:  srcb = 2'b01;
      B_ALUWB:  begin pcw = rdpc; rw = !rdpc; end
      B_BRANCH: begin srcb = 2'b01; res = 2'b10; pcw = 1; end
      default:  ;
    endcase
    return {mreq, pcw, rw, mw, irw, adr, res, srca, srcb, imm, rsrc, aluc};
  endfunction

  task automatic add(logic r, logic [19:0] i, logic [3:0] f, logic rd, bst_t s);
    vec_t v;
    v.rst_n = r; v.instr = i; v.aflags = f; v.ready = rd; v.st = s;
    vecs.push_back(v);
  endtask

  // One instruction that runs FETCH, DECODE, EXEC, ALUWB
  task automatic add_dp(logic [19:0] i, bst_t ex, logic [3:0] f);
    add(1, i, 4'h0, 1, B_FETCH);
    add(1, i, 4'h0, 0, B_DECODE);
    add(1, i, f,    0, ex);
    add(1, i, 4'h0, 1, B_ALUWB);
  endtask

  // Condition-failed or unimplemented instruction: FETCH, DECODE only
  task automatic add_nop(logic [19:0] i);
    add(1, i, 4'h0, 1, B_FETCH);
    add(1, i, 4'h0, 1, B_DECODE);
  endtask

  // Drive one cycle and queue the outputs expected during it
  task automatic step(logic r, logic [19:0] i, logic [3:0] f, logic rd, bst_t s);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    reset = r; Instr = i; ALUFlags = f; mem_ready = rd;
    e.outs = exp_outs(s, i, rd); e.st = s; e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Scoreboard consumer on the falling edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (act !== e.outs) begin
        n_errors++;
        $display("FAIL outs_%s cyc=%0d got=%05h want=%05h", e.st.name(), e.cyc, act, e.outs);
      end else begin
        $display("ok   cyc=%0d %-9s outs=%05h", e.cyc, e.st.name(), act);
      end
    end
  end

  initial begin
    // Reset held for two cycles: everything low
    add(0, 20'h0, 4'h0, 1, B_RST);
    add(0, 20'h0, 4'h0, 1, B_RST);
    // ADD R1,R0,#5
    add_dp(20'hE2801, B_EXECI, 4'h0);
    // SUBS R2,R1,R1 sets Z, then ADDEQ executes
    add_dp(20'hE0512, B_EXECR, 4'b0100);
    add_dp(20'h02803, B_EXECI, 4'h0);
    // SUBS again, then ADDNE is skipped
    add_dp(20'hE0512, B_EXECR, 4'b0100);
    add_nop(20'h12803);
    // STR R2,[R0,#100] with three wait cycles in MEMWR
    add(1, 20'hE5802, 4'h0, 1, B_FETCH);
    add(1, 20'hE5802, 4'h0, 1, B_DECODE);
    add(1, 20'hE5802, 4'h0, 0, B_MEMADR);
    add(1, 20'hE5802, 4'h0, 0, B_MEMWR);
    add(1, 20'hE5802, 4'h0, 0, B_MEMWR);
    add(1, 20'hE5802, 4'h0, 0, B_MEMWR);
    add(1, 20'hE5802, 4'h0, 1, B_MEMWR);
    // B with one fetch wait cycle
    add(1, 20'hEA000, 4'h0, 0, B_FETCH);
    add(1, 20'hEA000, 4'h0, 1, B_FETCH);
    add(1, 20'hEA000, 4'h0, 0, B_DECODE);
    add(1, 20'hEA000, 4'h0, 0, B_BRANCH);
    // Unimplemented EOR and Op=11 both retire as NOPs
    add_nop(20'hE2201);
    add_nop(20'hEF000);
    // ADDS sets C; ANDS loads N,Z only (V offered but must not load)
    add_dp(20'hE2901, B_EXECI, 4'b0010);
    add_dp(20'hE2111, B_EXECI, 4'b1001);
    add_dp(20'hE3801, B_EXECI, 4'h0);
    add_dp(20'h22803, B_EXECI, 4'h0);   // ADDCS: C kept
    add_nop(20'h62803);                 // ADDVS: V still clear
    add_dp(20'h42803, B_EXECI, 4'h0);   // ADDMI: N set by ANDS
    // SUB R15,R0,R0 writes the PC in ALUWB
    add_dp(20'hE040F, B_EXECR, 4'h0);
    // LDR R15,[R0,#0] with one wait in MEMRD
    add(1, 20'hE590F, 4'h0, 1, B_FETCH);
    add(1, 20'hE590F, 4'h0, 1, B_DECODE);
    add(1, 20'hE590F, 4'h0, 1, B_MEMADR);
    add(1, 20'hE590F, 4'h0, 0, B_MEMRD);
    add(1, 20'hE590F, 4'h0, 1, B_MEMRD);
    add(1, 20'hE590F, 4'h0, 1, B_MEMWB);
    // Z set again ahead of the reset-pulse sequence
    add_dp(20'hE0512, B_EXECR, 4'b0100);

    foreach (vecs[k])
      step(vecs[k].rst_n, vecs[k].instr, vecs[k].aflags, vecs[k].ready, vecs[k].st);

    // Reset pulsed in the middle of a MEMRD cycle
    step(1, 20'hE590F, 4'h0, 1, B_FETCH);
    step(1, 20'hE590F, 4'h0, 1, B_DECODE);
    step(1, 20'hE590F, 4'h0, 1, B_MEMADR);
    step(1, 20'hE590F, 4'h0, 1, B_MEMRD);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (act !== 17'h0) begin
      n_errors++;
      $display("FAIL midcycle_reset got=%05h want=00000", act);
    end else begin
      $display("ok   mid-cycle reset outs=%05h", act);
    end
    step(0, 20'hE590F, 4'h0, 1, B_RST);
    // Flags were cleared, so ADDEQ now fails (CPI 2)
    step(1, 20'h02803, 4'h0, 1, B_FETCH);
    step(1, 20'h02803, 4'h0, 1, B_DECODE);
    step(1, 20'hE2801, 4'h0, 1, B_FETCH);

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
